// File: rtl/mr_csr_pkg.sv
// Shared CSR definitions: address map, FSM states, write-merge and read-only decode helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mr_csr_pkg;

  localparam int XLEN   = 32;
  localparam int CSRLEN = 12;

  typedef enum logic [CSRLEN-1:0] {
    CSR_MISA      = 12'h301,
    CSR_MSCRATCH  = 12'h340,
    CSR_MCYCLE    = 12'hB00,
    CSR_MINSTRET  = 12'hB02,
    CSR_MCYCLEH   = 12'hB80,
    CSR_MINSTRETH = 12'hB82,
    CSR_CYCLE     = 12'hC00,
    CSR_TIME      = 12'hC01,
    CSR_INSTRET   = 12'hC02,
    CSR_CYCLEH    = 12'hC80,
    CSR_TIMEH     = 12'hC81,
    CSR_INSTRETH  = 12'hC82,
    CSR_MVENDORID = 12'hF11,
    CSR_MARCHID   = 12'hF12,
    CSR_MIMPID    = 12'hF13,
    CSR_MHARTID   = 12'hF14
  } e_csr_addr;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } e_state;

  // Addresses with the top two bits set are read-only in the CSR address space.
  function automatic logic csr_is_ro(input logic [CSRLEN-1:0] addr);
    return addr[CSRLEN-1:CSRLEN-2] == 2'b11;
  endfunction

  // Per-bit masked write: masked bits take new data, others keep the old value.
  function automatic logic [XLEN-1:0] wmerge(input logic [XLEN-1:0] old_val,
                                             input logic [XLEN-1:0] data,
                                             input logic [XLEN-1:0] mask);
    return (old_val & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/mr_csr_counter64.sv
// 64-bit free-running counter with masked write to either 32-bit half.
// Latency: increment/write visible on cnt the cycle after the edge that applies it.
// Backpressure: none; a write that cycle replaces the increment (no carry into the written half).
module mr_csr_counter64
  import mr_csr_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      inc,
  input  logic            we,
  input  logic            we_hi,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] wmask,
  output logic [63:0]     cnt
);

  logic [63:0] cnt_d, cnt_q;

  // Next value: write to the selected half wins over increment; 64-bit add wraps silently.
  always_comb begin
    cnt_d = cnt_q + 64'(inc);
    if (we) begin
      if (we_hi) begin
        cnt_d = {wmerge(cnt_q[63:32], wdata, wmask), cnt_q[31:0]};
      end else begin
        cnt_d = {cnt_q[63:32], wmerge(cnt_q[31:0], wdata, wmask)};
      end
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mr_csr.sv
// Machine CSR file responder beside decode: legality/fence decode, one RMW per request.
// Latency: return pulse exactly 1 cycle after accept, carrying the pre-write value.
// Backpressure: ready drops while a return is pending; next accept two cycles after the last.
module mr_csr
  import mr_csr_pkg::*;
#(
  parameter logic [XLEN-1:0] HART_ID  = '0,
  parameter logic [XLEN-1:0] MISA_VAL = 32'h40000100,
  parameter logic [XLEN-1:0] MIMPID   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csr_valid,
  input  logic              csr_r,
  input  logic              csr_w,
  input  logic [CSRLEN-1:0] csr_addr,
  input  logic [XLEN-1:0]   csr_data,
  input  logic [XLEN-1:0]   csr_wmask,
  output logic              csr_ready,
  output logic              csr_legal,
  output logic              csr_fence,
  output logic              csr_ret_valid,
  output logic [XLEN-1:0]   csr_ret_data,
  input  logic [2:0]        insts_ret
);

  e_state          state_d, state_q;
  logic [XLEN-1:0] ret_data_d, ret_data_q;
  logic [XLEN-1:0] mscratch_d, mscratch_q;
  logic [63:0]     mcycle, minstret;
  logic [XLEN-1:0] rdata;
  logic            impl;
  logic            accept, wr;

  // Address decode and read mux over the current (pre-write) CSR values.
  always_comb begin
    impl  = 1'b1;
    rdata = '0;
    case (csr_addr)
      CSR_MSCRATCH:                        rdata = mscratch_q;
      CSR_MISA:                            rdata = MISA_VAL;
      CSR_MCYCLE, CSR_CYCLE, CSR_TIME:     rdata = mcycle[31:0];
      CSR_MCYCLEH, CSR_CYCLEH, CSR_TIMEH:  rdata = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:           rdata = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH:         rdata = minstret[63:32];
      CSR_MVENDORID, CSR_MARCHID:          rdata = '0;
      CSR_MIMPID:                          rdata = MIMPID;
      CSR_MHARTID:                         rdata = HART_ID;
      default:                             impl  = 1'b0;
    endcase
  end

  assign csr_legal = impl & ~(csr_w & csr_is_ro(csr_addr));
  assign csr_fence = 1'b0;
  assign csr_ready = ~rst & (state_q == ST_IDLE);
  assign accept    = csr_valid & csr_ready & csr_legal;
  assign wr        = accept & csr_w;

  // Accept/response FSM, return capture and mscratch write.
  always_comb begin
    state_d    = state_q;
    ret_data_d = ret_data_q;
    mscratch_d = mscratch_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_RESP;
          ret_data_d = csr_r ? rdata : '0;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (wr && (csr_addr == CSR_MSCRATCH)) begin
      mscratch_d = wmerge(mscratch_q, csr_data, csr_wmask);
    end
  end

  // State, return and mscratch registers; reset drops any in-flight return.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ret_data_q <= '0;
      mscratch_q <= '0;
    end else begin
      state_q    <= state_d;
      ret_data_q <= ret_data_d;
      mscratch_q <= mscratch_d;
    end
  end

  assign csr_ret_valid = ~rst & (state_q == ST_RESP);
  assign csr_ret_data  = csr_ret_valid ? ret_data_q : '0;

  mr_csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (3'd1),
    .we    (wr & ((csr_addr == CSR_MCYCLE) | (csr_addr == CSR_MCYCLEH))),
    .we_hi (csr_addr == CSR_MCYCLEH),
    .wdata (csr_data),
    .wmask (csr_wmask),
    .cnt   (mcycle)
  );

  mr_csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (insts_ret),
    .we    (wr & ((csr_addr == CSR_MINSTRET) | (csr_addr == CSR_MINSTRETH))),
    .we_hi (csr_addr == CSR_MINSTRETH),
    .wdata (csr_data),
    .wmask (csr_wmask),
    .cnt   (minstret)
  );

endmodule
